// File: rtl/mem_1_access.sv
// rtl/mem_1_access.sv - second memory stage: data-memory access over req/ack, stalls upstream
//
// Purpose:
//   Consumes the registered m0_m1_* bundle from the address-calculation stage.
//   Non-memory ops pass through to writeback in one cycle. Aligned loads and
//   stores issue a registered request on the dmem req/ack port and stall
//   upstream until ack or timeout. Misaligned or timed-out accesses raise a
//   one-cycle exception to writeback.
//
// Ports:
//   clock, reset       pipeline clock (rising edge), async active-low reset
//   m0_m1_*            upstream instruction bundle, held stable while m1_stall=1
//   m1_stall           combinational hold request to upstream
//   dmem_req/we/addr/wdata   registered memory request, stable through the access
//   dmem_rdata/ack     memory response; rdata sampled only with ack
//   m1_wb_*            registered result bundle to writeback

`timescale 1ns/1ps

module mem_1_access #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_m1_oper,
  input  logic        m0_m1_readmem,
  input  logic        m0_m1_writemem,
  input  logic [31:0] m0_m1_data_addr,
  input  logic [31:0] m0_m1_regb,
  input  logic [4:0]  m0_m1_regdest,
  input  logic        m0_m1_writereg,
  output logic        m1_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        m1_wb_oper,
  output logic        m1_wb_writereg,
  output logic [4:0]  m1_wb_regdest,
  output logic [31:0] m1_wb_result,
  output logic        m1_wb_exc
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  // Counter value at which an unacknowledged access is aborted.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              req_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        dest_q;
  logic              wreg_q;
  logic              wb_oper_q;
  logic              wb_wreg_q;
  logic [4:0]        wb_dest_q;
  logic [31:0]       wb_result_q;
  logic              wb_exc_q;

  logic is_mem;
  logic aligned;
  logic timeout_hit;

  assign is_mem      = m0_m1_readmem | m0_m1_writemem;
  assign aligned     = (m0_m1_data_addr[1:0] == 2'b00);
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // Saturating increment so a long wait with timeout disabled cannot wrap.
  assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // Upstream may advance on the ack edge itself, so ack releases the stall.
  assign m1_stall = (state_q == S_ACCESS) & ~dmem_ack;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      dest_q      <= '0;
      wreg_q      <= 1'b0;
      wb_oper_q   <= 1'b0;
      wb_wreg_q   <= 1'b0;
      wb_dest_q   <= '0;
      wb_result_q <= '0;
      wb_exc_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Default: writeback bubble, no request.
          req_q       <= 1'b0;
          wb_oper_q   <= 1'b0;
          wb_wreg_q   <= 1'b0;
          wb_dest_q   <= '0;
          wb_result_q <= '0;
          wb_exc_q    <= 1'b0;
          if (m0_m1_oper) begin
            if (!is_mem) begin
              wb_oper_q   <= 1'b1;
              wb_wreg_q   <= m0_m1_writereg;
              wb_dest_q   <= m0_m1_regdest;
              wb_result_q <= m0_m1_data_addr;
            end else if (!aligned) begin
              wb_oper_q   <= 1'b1;
              wb_dest_q   <= m0_m1_regdest;
              wb_exc_q    <= 1'b1;
            end else begin
              // readmem and writemem together resolve to a store.
              req_q   <= 1'b1;
              we_q    <= m0_m1_writemem;
              addr_q  <= m0_m1_data_addr;
              wdata_q <= m0_m1_regb;
              dest_q  <= m0_m1_regdest;
              wreg_q  <= m0_m1_writereg;
              cnt_q   <= '0;
              state_q <= S_ACCESS;
            end
          end
        end

        S_ACCESS: begin
          wb_oper_q   <= 1'b0;
          wb_wreg_q   <= 1'b0;
          wb_dest_q   <= '0;
          wb_result_q <= '0;
          wb_exc_q    <= 1'b0;
          if (dmem_ack) begin
            req_q       <= 1'b0;
            wb_oper_q   <= 1'b1;
            wb_dest_q   <= dest_q;
            wb_wreg_q   <= we_q ? 1'b0 : wreg_q;
            wb_result_q <= we_q ? 32'd0 : dmem_rdata;
            state_q     <= S_IDLE;
          end else if (timeout_hit) begin
            req_q     <= 1'b0;
            wb_oper_q <= 1'b1;
            wb_dest_q <= dest_q;
            wb_exc_q  <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign m1_wb_oper     = wb_oper_q;
  assign m1_wb_writereg = wb_wreg_q;
  assign m1_wb_regdest  = wb_dest_q;
  assign m1_wb_result   = wb_result_q;
  assign m1_wb_exc      = wb_exc_q;

endmodule

// File: tb/tb_mem_1_access.sv
// tb/tb_mem_1_access.sv - self-checking bench for mem_1_access against a transaction-level model

`timescale 1ns/1ps

module tb_mem_1_access;

  localparam int TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_m1_oper;
  logic        m0_m1_readmem;
  logic        m0_m1_writemem;
  logic [31:0] m0_m1_data_addr;
  logic [31:0] m0_m1_regb;
  logic [4:0]  m0_m1_regdest;
  logic        m0_m1_writereg;
  logic        m1_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        m1_wb_oper;
  logic        m1_wb_writereg;
  logic [4:0]  m1_wb_regdest;
  logic [31:0] m1_wb_result;
  logic        m1_wb_exc;

  int n_total = 0;
  int n_pass  = 0;

  mem_1_access #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .m0_m1_oper      (m0_m1_oper),
    .m0_m1_readmem   (m0_m1_readmem),
    .m0_m1_writemem  (m0_m1_writemem),
    .m0_m1_data_addr (m0_m1_data_addr),
    .m0_m1_regb      (m0_m1_regb),
    .m0_m1_regdest   (m0_m1_regdest),
    .m0_m1_writereg  (m0_m1_writereg),
    .m1_stall        (m1_stall),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .m1_wb_oper      (m1_wb_oper),
    .m1_wb_writereg  (m1_wb_writereg),
    .m1_wb_regdest   (m1_wb_regdest),
    .m1_wb_result    (m1_wb_result),
    .m1_wb_exc       (m1_wb_exc)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},  m1_stall, 0);
    check({tag, "_req"},    dmem_req, 0);
    check({tag, "_we"},     dmem_we, 0);
    check({tag, "_addr"},   dmem_addr, 0);
    check({tag, "_wdata"},  dmem_wdata, 0);
    check({tag, "_wboper"}, m1_wb_oper, 0);
    check({tag, "_wbwreg"}, m1_wb_writereg, 0);
    check({tag, "_wbdest"}, m1_wb_regdest, 0);
    check({tag, "_wbres"},  m1_wb_result, 0);
    check({tag, "_wbexc"},  m1_wb_exc, 0);
  endtask

  // One instruction from upstream. ack_at = ACCESS cycle (1-based) in which
  // memory acks; 0 = never. Expected results come from the instruction's
  // architectural meaning, not from the DUT.
  task automatic run_op(input logic oper, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] regb,
                        input logic [4:0] dest, input logic wreg,
                        input int ack_at, input logic [31:0] rdata);
    logic is_mem, is_store, misaligned;
    bit   done;
    is_mem     = rd | wr;
    is_store   = wr;
    misaligned = (addr % 4) != 0;

    m0_m1_oper      = oper;
    m0_m1_readmem   = rd;
    m0_m1_writemem  = wr;
    m0_m1_data_addr = addr;
    m0_m1_regb      = regb;
    m0_m1_regdest   = dest;
    m0_m1_writereg  = wreg;
    dmem_ack        = 1'($urandom_range(0, 1));   // ack in IDLE must be ignored
    dmem_rdata      = $urandom;
    #1;
    check("idle_stall", m1_stall, 0);
    step();
    dmem_ack = 1'b0;

    if (!oper) begin
      check("bub_oper", m1_wb_oper, 0);
      check("bub_wreg", m1_wb_writereg, 0);
      check("bub_dest", m1_wb_regdest, 0);
      check("bub_res",  m1_wb_result, 0);
      check("bub_exc",  m1_wb_exc, 0);
      check("bub_req",  dmem_req, 0);
    end else if (!is_mem) begin
      check("pt_oper", m1_wb_oper, 1);
      check("pt_wreg", m1_wb_writereg, wreg);
      check("pt_dest", m1_wb_regdest, dest);
      check("pt_res",  m1_wb_result, addr);
      check("pt_exc",  m1_wb_exc, 0);
      check("pt_req",  dmem_req, 0);
    end else if (misaligned) begin
      check("mis_oper", m1_wb_oper, 1);
      check("mis_wreg", m1_wb_writereg, 0);
      check("mis_res",  m1_wb_result, 0);
      check("mis_exc",  m1_wb_exc, 1);
      check("mis_req",  dmem_req, 0);
    end else begin
      check("lat_req",   dmem_req, 1);
      check("lat_we",    dmem_we, is_store);
      check("lat_addr",  dmem_addr, addr);
      check("lat_wdata", dmem_wdata, regb);
      check("lat_oper",  m1_wb_oper, 0);
      done = 0;
      for (int k = 1; k <= 64 && !done; k++) begin
        if (k == ack_at) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
          #1;
          check("ack_stall", m1_stall, 0);
          step();
          dmem_ack   = 1'b0;
          dmem_rdata = $urandom;
          check("ack_req",  dmem_req, 0);
          check("ack_oper", m1_wb_oper, 1);
          check("ack_dest", m1_wb_regdest, dest);
          check("ack_wreg", m1_wb_writereg, is_store ? 1'b0 : wreg);
          check("ack_res",  m1_wb_result, is_store ? 32'd0 : rdata);
          check("ack_exc",  m1_wb_exc, 0);
          done = 1;
        end else begin
          dmem_rdata = $urandom;
          #1;
          check("wait_stall", m1_stall, 1);
          step();
          if (k == TIMEOUT) begin
            check("to_req",  dmem_req, 0);
            check("to_oper", m1_wb_oper, 1);
            check("to_wreg", m1_wb_writereg, 0);
            check("to_exc",  m1_wb_exc, 1);
            done = 1;
          end else begin
            check("wait_req",   dmem_req, 1);
            check("wait_addr",  dmem_addr, addr);
            check("wait_we",    dmem_we, is_store);
            check("wait_wdata", dmem_wdata, regb);
            check("wait_oper",  m1_wb_oper, 0);
            check("wait_exc",   m1_wb_exc, 0);
          end
        end
      end
      if (!done) check("access_bound", 0, 1);
    end
  endtask

  initial begin
    reset           = 1'b0;
    m0_m1_oper      = 1'b0;
    m0_m1_readmem   = 1'b0;
    m0_m1_writemem  = 1'b0;
    m0_m1_data_addr = '0;
    m0_m1_regb      = '0;
    m0_m1_regdest   = '0;
    m0_m1_writereg  = 1'b0;
    dmem_rdata      = '0;
    dmem_ack        = 1'b0;
    step();
    step();
    check_all_zero("rst");
    reset = 1'b1;

    // Reset asserted mid-access clears outputs without waiting for a clock.
    m0_m1_oper      = 1'b1;
    m0_m1_readmem   = 1'b1;
    m0_m1_data_addr = 32'h0000_0400;
    m0_m1_writereg  = 1'b1;
    m0_m1_regdest   = 5'd7;
    step();
    check("mid_req_up", dmem_req, 1);
    #1;
    check("mid_stall_up", m1_stall, 1);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    reset = 1'b1;

    // Directed cases.
    run_op(1, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 32'h0);              // passthrough
    run_op(1, 1, 0, 32'h0000_0100, 32'h0, 5'd9, 1, 3, 32'hDEAD_BEEF);      // load, ack in 3rd cycle
    run_op(1, 0, 0, 32'h0000_5678, 32'h0, 5'd3, 1, 0, 32'h0);              // captured right after ack
    run_op(1, 0, 1, 32'h0000_0200, 32'hCAFE_F00D, 5'd4, 1, 1, 32'h1111_2222); // store, immediate ack
    run_op(1, 1, 0, 32'h0000_0102, 32'h0, 5'd6, 1, 0, 32'h0);              // misaligned load
    run_op(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);                      // exc lasts one cycle
    run_op(1, 1, 1, 32'h0000_0300, 32'h1234_5678, 5'd8, 1, 2, 32'h5555_AAAA); // both set: store
    run_op(1, 1, 0, 32'h0000_0500, 32'h0, 5'd10, 1, 0, 32'h0);             // timeout
    run_op(1, 1, 0, 32'h0000_0600, 32'h0, 5'd11, 1, TIMEOUT, 32'h0BAD_F00D); // ack on last cycle wins

    // Late ack after timeout must be ignored.
    m0_m1_oper = 1'b0;
    dmem_ack   = 1'b1;
    #1;
    check("late_stall", m1_stall, 0);
    step();
    dmem_ack = 1'b0;
    check("late_req",  dmem_req, 0);
    check("late_oper", m1_wb_oper, 0);

    // Randomised instruction stream.
    for (int i = 0; i < 200; i++) begin
      logic        oper, rd, wr;
      logic [31:0] addr;
      int          kind;
      oper = ($urandom_range(0, 7) != 0);
      kind = $urandom_range(0, 3);
      rd   = (kind == 1) || (kind == 3);
      wr   = (kind == 2) || (kind == 3);
      addr = $urandom;
      if ($urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
      run_op(oper, rd, wr, addr, $urandom, 5'($urandom), 1'($urandom),
             $urandom_range(0, TIMEOUT + 1), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
